// File: rtl/m_icache.sv
// m_icache: direct-mapped instruction cache with 4-word line refill from an ack-handshaked memory
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module m_icache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic [31:0] w_pc,
  input  logic        w_re,
  input  logic        w_flush,
  output logic [31:0] w_ir,
  output logic        w_oe,
  output logic        w_mreq,
  output logic [31:0] w_maddr,
  input  logic [31:0] w_mdata,
  input  logic        w_mack
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [31:0] data [LINES*LINE_WORDS];
  logic [TW-1:0] r_ftag;
  logic [IW-1:0] r_findex;
  logic [1:0] r_fword;
  logic r_flush_pend;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, start, last, flush_seen, unused_ok;
  assign idx = w_pc[4+IW-1:4];
  assign tag = w_pc[31:4+IW];
  assign unused_ok = ^w_pc[1:0];
  always_comb begin
    hit = w_re & !w_flush & valid[idx] & (tags[idx] == tag) & (state == IDLE);
    start = (state == IDLE) & w_re & !hit & !w_flush;
    last = (state == FILL) & w_mack & (r_fword == 2'd3);
    flush_seen = r_flush_pend | w_flush;
    state_n = start ? FILL : last ? IDLE : state;
    w_oe = hit;
    w_ir = hit ? data[{idx, w_pc[3:2]}] : '0;
    w_mreq = state == FILL;
    w_maddr = w_mreq ? {r_ftag, r_findex, r_fword, 2'b00} : '0;
  end
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      valid <= '0;
      r_fword <= '0;
      r_flush_pend <= 1'b0;
      r_ftag <= '0;
      r_findex <= '0;
    end else begin
      if (start) begin
        r_ftag <= tag;
        r_findex <= idx;
        r_fword <= '0;
        valid[idx] <= 1'b0;
      end
      if (w_mreq & w_mack) r_fword <= r_fword + 2'd1;
      if (w_mreq & w_flush) r_flush_pend <= 1'b1;
      // a flush seen at any point of the fill keeps the new line invalid and drops all others
      if (last) begin
        r_flush_pend <= 1'b0;
        valid[r_findex] <= !flush_seen;
        if (flush_seen) valid <= '0;
      end
      if ((state == IDLE) & w_flush) valid <= '0;
    end
  end
  always_ff @(posedge w_clk) begin
    if (w_mreq & w_mack) data[{r_findex, r_fword}] <= w_mdata;
    if (last) tags[r_findex] <= r_ftag;
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] r_hits, r_misses;
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_hits <= '0;
      r_misses <= '0;
    end else begin
      if (hit) r_hits <= r_hits + 32'd1;
      if (start) r_misses <= r_misses + 32'd1;
    end
`endif
endmodule

// File: tb/tb_m_icache.sv
// tb_m_icache: directed bench for m_icache against a line-level cache model and fixed-content memory
module tb_m_icache;
  logic w_clk = 1'b0, w_rst_n = 1'b0, w_re = 1'b0, w_flush = 1'b0, w_mack = 1'b0;
  logic [31:0] w_pc = '0, w_mdata = '0;
  logic [31:0] w_ir, w_maddr;
  logic w_oe, w_mreq;
  m_icache dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_pc(w_pc), .w_re(w_re), .w_flush(w_flush),
    .w_ir(w_ir), .w_oe(w_oe), .w_mreq(w_mreq), .w_maddr(w_maddr),
    .w_mdata(w_mdata), .w_mack(w_mack)
  );
  always #5 w_clk = ~w_clk;
  int checks = 0, errors = 0;
  logic [31:0] pc = '0;
  logic re = 1'b0, flush = 1'b0;
  int gap = 1;
  logic m_valid [16];
  logic [27:0] m_line [16];
  logic m_fill = 1'b0, m_fl_seen = 1'b0;
  logic [27:0] m_fbase = '0;
  int m_nack = 0, m_gcnt = 0;
  logic last_oe;
  logic [31:0] last_ir;
  logic [31:0] ack_addrs [$];
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_fill = 1'b0;
    m_fl_seen = 1'b0;
    m_nack = 0;
    m_gcnt = 0;
  endtask
  // one clock cycle: drive, compare against the model, then advance the model at the edge
  task automatic tick();
    int idx;
    logic e_oe, ack;
    logic [31:0] e_ir, e_maddr;
    idx = int'(pc[7:4]);
    e_oe = re & !flush & !m_fill & m_valid[idx] & (m_line[idx] == pc[31:4]);
    e_ir = e_oe ? mem({pc[31:2], 2'b00}) : 32'h0;
    e_maddr = m_fill ? {m_fbase, m_nack[1:0], 2'b00} : 32'h0;
    ack = m_fill && (m_gcnt >= gap - 1);
    w_pc = pc;
    w_re = re;
    w_flush = flush;
    w_mack = ack;
    w_mdata = ack ? mem(e_maddr) : 32'h0;
    #1;
    chk("oe", {31'h0, w_oe}, {31'h0, e_oe});
    chk("ir", w_ir, e_ir);
    chk("mreq", {31'h0, w_mreq}, {31'h0, m_fill});
    chk("maddr", w_maddr, e_maddr);
    last_oe = w_oe;
    last_ir = w_ir;
    if (ack) ack_addrs.push_back(w_maddr);
    @(posedge w_clk);
    if (!m_fill) begin
      if (flush) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (re && !e_oe) begin
        m_fill = 1'b1;
        m_fbase = pc[31:4];
        m_nack = 0;
        m_gcnt = 0;
        m_fl_seen = 1'b0;
        m_valid[idx] = 1'b0;
      end
    end else begin
      if (flush) m_fl_seen = 1'b1;
      if (ack) begin
        m_nack++;
        m_gcnt = 0;
        if (m_nack == 4) begin
          m_fill = 1'b0;
          if (m_fl_seen) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
          end else begin
            m_valid[int'(m_fbase[3:0])] = 1'b1;
            m_line[int'(m_fbase[3:0])] = m_fbase;
          end
        end
      end else m_gcnt++;
    end
    #1;
  endtask
  task automatic fetch(input logic [31:0] a, output int n);
    pc = a;
    re = 1'b1;
    n = 0;
    ack_addrs.delete();
    tick();
    while (!last_oe && n < 60) begin
      n++;
      tick();
    end
    if (!last_oe) chk("fetch_timeout", a, 32'hFFFF_FFFF);
  endtask
  task automatic chk_addrs(input string nm, input logic [31:0] base);
    chk({nm, "_nacks"}, ack_addrs.size(), 4);
    for (int i = 0; i < 4 && i < ack_addrs.size(); i++) chk(nm, ack_addrs[i], base + 32'(4 * i));
  endtask
  int n;
  initial begin
    model_reset();
    #1;
    chk("rst_oe", {31'h0, w_oe}, 32'h0);
    chk("rst_ir", w_ir, 32'h0);
    chk("rst_mreq", {31'h0, w_mreq}, 32'h0);
    chk("rst_maddr", w_maddr, 32'h0);
    #11 w_rst_n = 1'b1;
    @(posedge w_clk);
    #1;
    fetch(32'h10, n);
    chk("cold_lat", n, 5);
    chk_addrs("cold_addr", 32'h10);
    chk("cold_ir", last_ir, 32'hC0DE0010);
    pc = 32'h1C;
    tick();
    chk("same_line_hit", {31'h0, last_oe}, 32'h1);
    chk("same_line_ir", last_ir, 32'hC0DE001C);
    fetch(32'h110, n);
    chk("conflict_lat", n, 5);
    chk_addrs("conflict_addr", 32'h110);
    fetch(32'h10, n);
    chk("refetch_lat", n, 5);
    gap = 3;
    pc = 32'h40;
    re = 1'b1;
    ack_addrs.delete();
    tick();
    pc = 32'h300;
    for (int i = 0; i < 6; i++) tick();
    pc = 32'h40;
    n = 7;
    tick();
    while (!last_oe && n < 60) begin
      n++;
      tick();
    end
    chk("slow_lat", n, 13);
    chk_addrs("slow_addr", 32'h40);
    chk("slow_ir", last_ir, 32'hC0DE0040);
    gap = 1;
    pc = 32'h10;
    flush = 1'b1;
    tick();
    chk("flush_idle_nohit", {31'h0, last_oe}, 32'h0);
    flush = 1'b0;
    fetch(32'h10, n);
    chk("after_flush_lat", n, 5);
    pc = 32'h20;
    ack_addrs.delete();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 3;
    tick();
    while (!last_oe && n < 60) begin
      n++;
      tick();
    end
    chk("flush_fill_lat", n, 10);
    fetch(32'h10, n);
    chk("flush_fill_other_line", n, 5);
    pc = 32'h30;
    ack_addrs.delete();
    tick();
    tick();
    tick();
    w_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstmid_mreq", {31'h0, w_mreq}, 32'h0);
    chk("rstmid_oe", {31'h0, w_oe}, 32'h0);
    re = 1'b0;
    w_re = 1'b0;
    w_mack = 1'b0;
    @(posedge w_clk);
    @(posedge w_clk);
    #3 w_rst_n = 1'b1;
    @(posedge w_clk);
    #1;
    fetch(32'h10, n);
    chk("rstmid_refill_lat", n, 5);
    chk_addrs("rstmid_addr", 32'h10);
    for (int i = 1; i <= 4; i++) begin
      pc = 32'h10 + 32'(4 * (i % 4));
      tick();
      chk("seq_hit", {31'h0, last_oe}, 32'h1);
    end
`ifdef ICACHE_STATS_EN
    chk("stat_misses", dut.r_misses, 32'd1);
    chk("stat_hits", dut.r_hits, 32'd5);
`endif
    fetch(32'h30, n);
    chk("rstmid_line_invalid", n, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_icache.md
# m_icache

Direct-mapped instruction cache between the pipelined core's fetch port and a slow, ack-handshaked backing instruction memory. On a hit it returns the instruction word in the same cycle. A hit also asserts w_oe, and the core stalls on !w_oe. On a miss it refills a four-word line from the backing memory, then serves the access as a hit.

## Interface
Parameters:
- LINES, 16, number of lines; power of two, ≥2
- LINE_WORDS, 4, words per line; fixed at 4 (offset = w_pc[3:2])

Ports:
- w_clk  input  1  clock, all state updates on rising edge
- w_rst_n  input  1  asynchronous active-low reset
- w_pc  input  32  fetch byte address; bits [1:0] ignored
- w_re  input  1  fetch request
- w_flush  input  1  one-cycle pulse: invalidate all lines
- w_ir  output  32  instruction word for w_pc; valid only when w_oe=1
- w_oe  output  1  w_ir valid this cycle (hit)
- w_mreq  output  1  backing-memory request, level
- w_maddr  output  32  backing-memory word byte-address, [1:0]=00
- w_mdata  input  32  backing-memory read data, sampled when w_mack=1
- w_mack  input  1  backing-memory acknowledge, one cycle per word

## Operation
- Address split: offset = w_pc[3:2]; index = w_pc[3+log2(LINES):4]; tag = remaining upper bits.
- Storage: per-line valid bit and tag register, plus LINES×4 word data array, all flops. Reads are combinational.
- Hit = w_re & valid[index] & (tag[index]==tag(w_pc)) & state==IDLE.
  - w_oe = hit.
  - w_ir = data[index][offset] when hit, else 0.
- FSM states: IDLE, FILL.
  - IDLE→FILL: w_re & !hit & !w_flush.
    - Capture r_ftag and r_findex from w_pc.
    - Set r_fword=0.
    - Clear valid[r_findex].
  - FILL: w_mreq=1, w_maddr={r_ftag, r_findex, r_fword, 2'b00}.
    - On w_mack: write w_mdata to data[r_findex][r_fword], then r_fword+1.
    - On the ack with r_fword==3: write tag, set valid unless a flush was seen during the fill, go to IDLE.
  - FILL ignores w_pc and w_re. A fill always completes for the captured address, even if w_pc changes.
- Flush:
  - In IDLE: clears all valid bits the next edge. The cycle carrying w_flush reports no hit and does not start a fill.
  - In FILL: latched into r_flush_pend. All valids clear when the fill ends, and the filled line is not marked valid.
- w_mack while in IDLE is ignored.
- Backing memory must hold w_mack low unless w_mreq=1. w_mdata must correspond to the w_maddr presented in the ack cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State = IDLE.
  - All valid bits = 0, r_fword=0, r_flush_pend=0.
  - w_oe=0, w_ir=0, w_mreq=0, w_maddr=0.
  - Data and tag arrays are not reset.
- Hit latency: 0 cycles (combinational from w_pc).
- Miss penalty with a backing memory acking every cycle:
  - Miss detected in cycle N.
  - w_mreq high in N+1..N+4.
  - Hit in N+5.
- General miss penalty: 1 + Σ(cycles to each of 4 acks) + 1 cycles until w_oe.
- w_maddr is stable from the edge entering FILL or following an ack until the next ack.
- Reset mid-fill: fill aborted immediately. w_mreq drops asynchronously and no valid bit is set. A partially written line stays invalid.
- Simultaneous w_flush and miss in IDLE: flush wins, no fill starts.

## Configuration
- ICACHE_STATS_EN defined:
  - Adds 32-bit registers r_hits and r_misses, reset to 0 and wrapping at 2^32.
  - r_hits increments on each cycle with w_oe=1.
  - r_misses increments on each IDLE→FILL transition.
  - Both are read hierarchically by the simulation harness for $display.
- Undefined: registers absent, with no port or behavioural difference.

## Test plan
- Cold miss, memory acks every cycle:
  - Stimulus: reset, w_re=1, w_pc=0x00000010.
  - w_mreq high four cycles with w_maddr 0x10, 0x14, 0x18, 0x1C.
  - w_oe=1 on the 6th cycle with w_ir = word at 0x10.
  - w_pc=0x1C is then a same-cycle hit.
- Conflict: after line 0x10 is filled, fetch 0x110 (LINES=16, same index, different tag). Required response:
  - Miss and refill from 0x110.
  - Re-fetch of 0x10 then misses again.
- Slow memory: w_mack every 3rd cycle, 4 acks. Required response:
  - w_maddr holds each address until its ack.
  - w_oe asserts 1 cycle after the 4th ack.
  - Changing w_pc mid-fill does not alter fill addresses.
- Flush:
  - Flush in IDLE after a fill: the next fetch of 0x10 misses.
  - Flush pulse during a fill: the fill completes, the same address misses again, and all lines read invalid.
- Reset mid-fill: deassert w_rst_n after the 2nd ack. Required response:
  - w_mreq=0 and w_oe=0 immediately.
  - After release, fetch 0x10 misses and refills from 0x10.
- With ICACHE_STATS_EN: 1 miss plus 4 sequential hits gives r_misses=1, r_hits=5 (the post-fill hit included).
